// File: rtl/mdr_mem_port_if.sv
// Request/response bus between the datapath (MDR/MAR side) and the memory port.
// The master drives a level request with its operands. The slave returns load data,
// a one-cycle completion pulse, a busy flag and an out-of-range flag.
interface mdr_mem_port_if #(
    parameter int ADDR_W = 8
);
    logic              req;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [15:0]       wdata;
    logic [15:0]       rdata;
    logic              ack;
    logic              busy;
    logic              err;

    modport master (
        output req, we, addr, wdata,
        input  rdata, ack, busy, err
    );

    modport slave (
        input  req, we, addr, wdata,
        output rdata, ack, busy, err
    );
endinterface

// File: rtl/mdr_mem_port.sv
// mdr_mem_port: memory-side responder for the datapath's MDR/MAR loads and stores.
// It holds a DEPTH x 16-bit data array and serves one request at a time.
//
// Each access follows IDLE -> WAIT (WAIT_CYCLES + 1 cycles) -> DONE. The array is
// read or written on the last WAIT edge. The ack and err outputs pulse for the
// single DONE cycle. rdata holds the most recent read result.
//
// Optional feature, selected by the macro MDR_MEM_BOUNDS_CHECK_EN:
//   defined   - an address >= DEPTH performs no access, leaves rdata unchanged,
//               and raises err together with ack.
//   undefined - out-of-range writes are dropped, out-of-range reads load 0,
//               and err is tied low.
module mdr_mem_port #(
    parameter int ADDR_W      = 8,
    parameter int DEPTH       = 256,
    parameter int WAIT_CYCLES = 2
) (
    input  logic          clk,
    input  logic          rst,
    mdr_mem_port_if.slave bus
);

    // Index width into the implemented array. DEPTH <= 2**ADDR_W, so this never exceeds ADDR_W.
    localparam int              MEM_AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    // Widened by one bit so that DEPTH == 2**ADDR_W is still representable.
    localparam logic [ADDR_W:0] DEPTH_LIM = DEPTH[ADDR_W:0];
    localparam logic [3:0]      WAIT_INIT = WAIT_CYCLES[3:0];

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t            state_q;
    logic [3:0]        cnt_q;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [15:0]       wdata_q;
    logic [15:0]       rdata_q;
    logic              ack_q;
    logic              busy_q;
`ifdef MDR_MEM_BOUNDS_CHECK_EN
    logic              err_q;
`endif

    logic [15:0]       mem [DEPTH];

    logic              commit;
    logic              in_range;
    logic [MEM_AW-1:0] mem_idx;

    // The commit edge is the last edge spent in WAIT, after the counter has drained.
    assign commit   = (state_q == S_WAIT) && (cnt_q == 4'd0);
    assign in_range = ({1'b0, addr_q} < DEPTH_LIM);
    assign mem_idx  = addr_q[MEM_AW-1:0];

    // Data array write port. It is not reset.
    // Only a write that reaches its commit edge lands in the array.
    always_ff @(posedge clk) begin
        if (commit && we_q && in_range) begin
            mem[mem_idx] <= wdata_q;
        end
    end

    // Request FSM.
    // It latches operands on acceptance, counts wait states, commits reads,
    // and drives the registered ack, busy and err outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= 16'h0000;
            rdata_q <= 16'h0000;
            ack_q   <= 1'b0;
            busy_q  <= 1'b0;
`ifdef MDR_MEM_BOUNDS_CHECK_EN
            err_q   <= 1'b0;
`endif
        end else begin
            // ack and err are single-cycle pulses. By default they are cleared.
            ack_q <= 1'b0;
`ifdef MDR_MEM_BOUNDS_CHECK_EN
            err_q <= 1'b0;
`endif
            case (state_q)
                S_IDLE: begin
                    if (bus.req) begin
                        we_q    <= bus.we;
                        addr_q  <= bus.addr;
                        wdata_q <= bus.wdata;
                        cnt_q   <= WAIT_INIT;
                        busy_q  <= 1'b1;
                        state_q <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (cnt_q != 4'd0) begin
                        cnt_q <= cnt_q - 4'd1;
                    end else begin
                        if (!we_q) begin
                            if (in_range) begin
                                rdata_q <= mem[mem_idx];
                            end
`ifndef MDR_MEM_BOUNDS_CHECK_EN
                            else begin
                                rdata_q <= 16'h0000;
                            end
`endif
                        end
`ifdef MDR_MEM_BOUNDS_CHECK_EN
                        err_q <= ~in_range;
`endif
                        ack_q   <= 1'b1;
                        state_q <= S_DONE;
                    end
                end
                S_DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.rdata = rdata_q;
    assign bus.ack   = ack_q;
    assign bus.busy  = busy_q;
`ifdef MDR_MEM_BOUNDS_CHECK_EN
    assign bus.err   = err_q;
`else
    assign bus.err   = 1'b0;
`endif

endmodule

// File: tb/tb_mdr_mem_port.sv
// Testbench for mdr_mem_port.
// dut0: ADDR_W=8, DEPTH=128, WAIT_CYCLES=2 (exercises the out-of-range behaviour).
// dut1: ADDR_W=8, DEPTH=256, WAIT_CYCLES=0.
// Expected values come from a word-array reference model of the access rules.
module tb_mdr_mem_port;

    localparam int D0 = 128;
    localparam int W0 = 2;
    localparam int D1 = 256;
    localparam int W1 = 0;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    mdr_mem_port_if #(.ADDR_W(8)) if0 ();
    mdr_mem_port_if #(.ADDR_W(8)) if1 ();

    mdr_mem_port #(.ADDR_W(8), .DEPTH(D0), .WAIT_CYCLES(W0)) dut0 (
        .clk (clk),
        .rst (rst),
        .bus (if0)
    );

    mdr_mem_port #(.ADDR_W(8), .DEPTH(D1), .WAIT_CYCLES(W1)) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (if1)
    );

    int errors = 0;
    int checks = 0;

    // Reference model: contents per DUT, a per-word "written" flag, and the last read value.
    logic [15:0] memm [2][256];
    bit          memk [2][256];
    logic [15:0] rdm  [2];
    bit          rdk  [2];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic drive(input int d, input logic r, input logic w,
                         input logic [7:0] a, input logic [15:0] wd);
        if (d == 0) begin
            if0.req = r; if0.we = w; if0.addr = a; if0.wdata = wd;
        end else begin
            if1.req = r; if1.we = w; if1.addr = a; if1.wdata = wd;
        end
    endtask

    // Packs the DUT outputs as {ack, busy, err, rdata}.
    function automatic logic [18:0] obs(input int d);
        if (d == 0) return {if0.ack, if0.busy, if0.err, if0.rdata};
        return {if1.ack, if1.busy, if1.err, if1.rdata};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            rdm[i] = 16'h0000;
            rdk[i] = 1'b1;
        end
    endtask

    task automatic model_access(input int d, input bit w, input logic [7:0] a,
                                input logic [15:0] wd, output bit exp_err);
        int depth;
        depth   = (d == 0) ? D0 : D1;
        exp_err = 1'b0;
        if (int'(a) < depth) begin
            if (w) begin
                memm[d][a] = wd;
                memk[d][a] = 1'b1;
            end else begin
                rdm[d] = memm[d][a];
                rdk[d] = memk[d][a];
            end
        end else begin
`ifdef MDR_MEM_BOUNDS_CHECK_EN
            exp_err = 1'b1;
`else
            if (!w) begin
                rdm[d] = 16'h0000;
                rdk[d] = 1'b1;
            end
`endif
        end
    endtask

    // Runs one access end to end.
    // scramble:  randomise the inputs while the DUT is busy.
    // hold:      keep req asserted through ack.
    // preloaded: the request is already on the bus.
    task automatic txn(input int d, input bit w, input logic [7:0] a, input logic [15:0] wd,
                       input bit scramble, input bit hold, input bit preloaded);
        int          waitc;
        int          n;
        logic [18:0] o;
        bit          exp_err;
        waitc = (d == 0) ? W0 : W1;
        if (!preloaded) begin
            @(negedge clk);
            drive(d, 1'b1, w, a, wd);
        end
        @(posedge clk); #1;
        o = obs(d);
        chk("accept_busy", 32'(o[17]), 32'd1);
        chk("accept_ack", 32'(o[18]), 32'd0);
        n = 0;
        do begin
            @(negedge clk);
            if (scramble)
                drive(d, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                      8'($urandom), 16'($urandom));
            else if (!hold)
                drive(d, 1'b0, w, a, wd);
            @(posedge clk); #1;
            n++;
            o = obs(d);
            if (!o[18]) chk("wait_busy", 32'(o[17]), 32'd1);
        end while (!o[18] && n < 40);
        chk("ack_latency", 32'(n), 32'(waitc + 1));
        model_access(d, w, a, wd, exp_err);
        chk("done_busy", 32'(o[17]), 32'd1);
        chk("done_err", 32'(o[16]), 32'(exp_err));
        if (rdk[d]) chk("done_rdata", 32'(o[15:0]), 32'(rdm[d]));
        $display("txn dut%0d we=%0b addr=%02h wdata=%04h rdata=%04h err=%0b lat=%0d",
                 d, w, a, wd, o[15:0], o[16], n);
        @(negedge clk);
        if (!hold) drive(d, 1'b0, w, a, wd);
        @(posedge clk); #1;
        o = obs(d);
        chk("idle_ack", 32'(o[18]), 32'd0);
        chk("idle_busy", 32'(o[17]), 32'd0);
        chk("idle_err", 32'(o[16]), 32'd0);
        if (rdk[d]) chk("idle_rdata", 32'(o[15:0]), 32'(rdm[d]));
    endtask

    initial begin
        logic [18:0] o;
        logic [7:0]  ra;
        drive(0, 1'b0, 1'b0, 8'h00, 16'h0000);
        drive(1, 1'b0, 1'b0, 8'h00, 16'h0000);
        for (int i = 0; i < 256; i++) begin
            memk[0][i] = 1'b0;
            memk[1][i] = 1'b0;
        end
        model_reset();

        // Reset state of both instances.
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            o = obs(d);
            chk("reset_ack", 32'(o[18]), 32'd0);
            chk("reset_busy", 32'(o[17]), 32'd0);
            chk("reset_err", 32'(o[16]), 32'd0);
            chk("reset_rdata", 32'(o[15:0]), 32'h0);
        end
        @(negedge clk);
        rst = 1'b0;

        // Write then read 0x10, both with WAIT_CYCLES=2.
        txn(0, 1'b1, 8'h10, 16'hBEEF, 1'b0, 1'b0, 1'b0);
        txn(0, 1'b0, 8'h10, 16'h0000, 1'b0, 1'b0, 1'b0);

        // Inputs changing during WAIT are ignored, and mem[0x20] survives.
        txn(0, 1'b1, 8'h20, 16'h2020, 1'b0, 1'b0, 1'b0);
        txn(0, 1'b0, 8'h10, 16'h0000, 1'b1, 1'b0, 1'b0);
        txn(0, 1'b0, 8'h20, 16'h0000, 1'b0, 1'b0, 1'b0);

        // req held high across ack: the second request is accepted after one idle cycle.
        txn(0, 1'b1, 8'h01, 16'h1234, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        drive(0, 1'b1, 1'b0, 8'h01, 16'h0000);
        txn(0, 1'b0, 8'h01, 16'h0000, 1'b0, 1'b0, 1'b1);

        // An asynchronous reset during a write's WAIT aborts the write.
        txn(0, 1'b1, 8'h05, 16'h5555, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        drive(0, 1'b1, 1'b1, 8'h05, 16'hAAAA);
        @(posedge clk); #1;
        o = obs(0);
        chk("abort_accept_busy", 32'(o[17]), 32'd1);
        @(negedge clk);
        drive(0, 1'b0, 1'b0, 8'h00, 16'h0000);
        #2 rst = 1'b1;
        #1;
        model_reset();
        o = obs(0);
        chk("abort_busy", 32'(o[17]), 32'd0);
        chk("abort_ack", 32'(o[18]), 32'd0);
        chk("abort_rdata", 32'(o[15:0]), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            o = obs(0);
            chk("abort_no_ack", 32'(o[18]), 32'd0);
        end
        txn(0, 1'b0, 8'h05, 16'h0000, 1'b0, 1'b0, 1'b0);

        // WAIT_CYCLES=0 instance at the top address.
        txn(1, 1'b0, 8'hFF, 16'h0000, 1'b0, 1'b0, 1'b0);
        txn(1, 1'b1, 8'hFF, 16'h00C3, 1'b0, 1'b0, 1'b0);
        txn(1, 1'b0, 8'hFF, 16'h0000, 1'b0, 1'b0, 1'b0);

        // Out-of-range read on the DEPTH=128 instance.
        txn(0, 1'b1, 8'h22, 16'h1111, 1'b0, 1'b0, 1'b0);
        txn(0, 1'b0, 8'h22, 16'h0000, 1'b0, 1'b0, 1'b0);
        txn(0, 1'b0, 8'h90, 16'h0000, 1'b0, 1'b0, 1'b0);

        // Randomised traffic. Addresses are biased towards a small window so reads hit written words.
        for (int i = 0; i < 30; i++) begin
            ra = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(8'h40, 8'h47));
            txn(0, 1'($urandom_range(0, 1)), ra, 16'($urandom), 1'b1, 1'b0, 1'b0);
        end
        for (int i = 0; i < 20; i++) begin
            ra = 8'($urandom_range(8'hF8, 8'hFF));
            txn(1, 1'($urandom_range(0, 1)), ra, 16'($urandom), 1'b1, 1'b0, 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mdr_mem_port.md
Name: mdr_mem_port

Overview:
- Memory-side responder serving the datapath's MDR/MAR load and store requests.
- Holds the 16-bit data memory array and accepts one request at a time over a req/ack handshake.
- Inserts a programmable number of wait states per access.
- Returns read data on rdata and pulses ack when the access completes.

Parameters:
- ADDR_W, 8, width of the word address.
- DEPTH, 256, number of 16-bit words implemented; must satisfy DEPTH <= 2**ADDR_W.
- WAIT_CYCLES, 2, wait states inserted between request acceptance and access commit (0..15).

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  reset, asynchronous, active-high.
- req  input  1  request strobe; level, sampled only in IDLE.
- we  input  1  1 = write (store from MDR), 0 = read (load into MDR); sampled with req.
- addr  input  ADDR_W  word address (from MAR); sampled with req.
- wdata  input  16  store data (from MDR); sampled with req.
- rdata  output  16  load data to MDR; registered.
- ack  output  1  one-cycle completion pulse.
- busy  output  1  high while a request is in flight (WAIT or DONE).
- err  output  1  out-of-range flag, pulses with ack (see Optional Feature).

Behaviour:
- Reset (asynchronous, immediate):
  - state=IDLE, rdata=16'h0000, ack=0, busy=0, err=0, wait counter=0.
  - Latched request registers are cleared.
  - Memory contents are NOT reset.
- FSM states: IDLE, WAIT, DONE.
- IDLE:
  - On a clk edge with req=1: latch we/addr/wdata, load cnt=WAIT_CYCLES, go to WAIT, busy=1.
  - With req=0: stay in IDLE.
- WAIT:
  - On each edge with cnt!=0: cnt decrements.
  - On the edge with cnt==0 (commit edge):
    - Write: mem[addr_l] <= wdata_l.
    - Read: rdata <= mem[addr_l].
    - Go to DONE; ack=1.
- DONE:
  - ack=1 for exactly this one cycle.
  - Next edge: go to IDLE, ack=0, busy=0.
- Latency: if req is sampled at edge k, ack is high in the cycle after edge k+WAIT_CYCLES+1.
  - Total per access: WAIT_CYCLES+2 cycles including DONE.
- Hold rules:
  - rdata keeps its last read value until the next read commits.
  - Writes never change rdata.
- Input changes while busy=1: req, we, addr and wdata are ignored. Only the latched copies are used.
- Back-to-back requests:
  - Requester drops req in the cycle ack is seen.
  - If req is still high when IDLE is re-entered, it is accepted as a new request; this is legal and gives 1 idle cycle between transactions.
- Same address, write then read: the read returns the new data. The write commits before the read is accepted.
- Reset mid-operation: the transaction is aborted.
  - A write whose commit edge has not occurred is not performed.
  - No ack is issued.
- WAIT_CYCLES=0: commit happens on the edge after acceptance.
- Memory indexing: address compared and indexed as an unsigned ADDR_W value.

Optional Feature:
- Macro: MDR_MEM_BOUNDS_CHECK_EN.
- Defined:
  - A request with addr_l >= DEPTH performs no access.
  - rdata is unchanged.
  - err=1 in the same cycle as ack (one cycle only).
  - Timing is identical to a normal access.
- Undefined:
  - Out-of-range writes are silently dropped.
  - Out-of-range reads load rdata=16'h0000.
  - err is tied 0.

Test Plan:
1. Reset, then write addr=8'h10 wdata=16'hBEEF, then read addr=8'h10 (WAIT_CYCLES=2) -> ack is high 3 cycles after each req-sample edge, rdata=16'hBEEF with the read ack, busy high for 4 cycles per access.
2. During a WAIT-state read of 8'h10, change addr to 8'h20 and raise we -> ignored; read completes with rdata=16'hBEEF and mem[8'h20] is unchanged.
3. Hold req high across ack: write 8'h01=16'h1234 then read 8'h01 -> second request accepted one cycle after DONE, rdata=16'h1234, exactly one ack pulse per transaction.
4. Assert rst in WAIT during a write of 16'hAAAA to 8'h05 (previously 16'h5555) -> ack never pulses, busy=0 immediately; a later read of 8'h05 returns 16'h5555.
5. WAIT_CYCLES=0, read an unwritten-then-written address 8'hFF=16'h00C3 -> ack in the second cycle after the req-sample edge, rdata=16'h00C3.
6. DEPTH=128, ADDR_W=8, read addr=8'h90 after rdata=16'h1111 -> with MDR_MEM_BOUNDS_CHECK_EN: err=1 with ack and rdata=16'h1111; without it: err=0 and rdata=16'h0000.
